// File: rtl/fmap_stream_tx_pkg.sv
// Shared CNN feature-map defaults and the transmitter state encoding.
package fmap_stream_tx_pkg;

  localparam int unsigned FMAP_WIDTH     = 12;
  localparam int unsigned FMAP_HEIGHT    = 12;
  localparam int unsigned FMAP_DATA_BITS = 14;
  localparam int unsigned FMAP_CHANNELS  = 3;
  localparam int unsigned CH_W           = 2;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } fmap_state_t;

endpackage

// File: rtl/fmap_ram.sv
// Frame buffer: one wide write port (all channels of a pixel) and one
// registered read port selecting a single channel word.
module fmap_ram
  import fmap_stream_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = FMAP_WIDTH * FMAP_HEIGHT,
  parameter int unsigned DATA_BITS = FMAP_DATA_BITS,
  parameter int unsigned CHANNELS  = FMAP_CHANNELS,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  wr_data,
  input  logic                                re,
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic [CH_W-1:0]                     rd_ch,
  output logic [DATA_BITS-1:0]                rd_data
);

  logic [DATA_BITS-1:0] mem [CHANNELS][DEPTH];

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mem[c][wr_addr] <= wr_data[c];
      end
    end
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_ch][rd_addr];
    end
  end

endmodule

// File: rtl/fmap_stream_tx.sv
// Collects one full multi-channel feature map, then streams it out
// channel-major, one sample per cycle.
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = FMAP_WIDTH,
  parameter int unsigned HEIGHT    = FMAP_HEIGHT,
  parameter int unsigned DATA_BITS = FMAP_DATA_BITS,
  parameter int unsigned CHANNELS  = FMAP_CHANNELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_BITS-1:0]  data_in_0,
  input  logic [DATA_BITS-1:0]  data_in_1,
  input  logic [DATA_BITS-1:0]  data_in_2,
  output logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_BITS-1:0]  data_out,
  output logic [1:0]            ch_idx,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned DEPTH  = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

  fmap_state_t       state, state_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [CH_W-1:0]   rd_ch, rd_ch_nxt;
  logic              we_c, re_c, last_c;

  logic [CHANNELS-1:0][DATA_BITS-1:0] wr_data;

  assign wr_data = {data_in_2, data_in_1, data_in_0};

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_ch      <= '0;
      ready_in   <= 1'b1;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      ch_idx     <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      rd_addr    <= rd_addr_nxt;
      rd_ch      <= rd_ch_nxt;
      ready_in   <= (state_nxt == ST_FILL);
      valid_out  <= re_c;
      frame_done <= last_c;
      if (re_c) begin
        ch_idx <= rd_ch;
      end
      if (valid_in && !ready_in) begin
        overflow <= 1'b1;
      end
    end
  end

  // Next-state, counter advance and memory strobes. The DRAIN state lingers
  // for the frame_done cycle so ready_in rises only on the following cycle.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    rd_ch_nxt   = rd_ch;
    we_c        = 1'b0;
    re_c        = 1'b0;
    last_c      = 1'b0;
    case (state)
      ST_FILL: begin
        if (valid_in) begin
          we_c = 1'b1;
          if (wr_addr == ADDR_LAST) begin
            wr_addr_nxt = '0;
            state_nxt   = ST_DRAIN;
          end else begin
            wr_addr_nxt = wr_addr + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (frame_done) begin
          state_nxt = ST_FILL;
        end else begin
          re_c = 1'b1;
          if (rd_addr == ADDR_LAST) begin
            rd_addr_nxt = '0;
            if (rd_ch == CH_LAST) begin
              rd_ch_nxt = '0;
              last_c    = 1'b1;
            end else begin
              rd_ch_nxt = rd_ch + CH_W'(1);
            end
          end else begin
            rd_addr_nxt = rd_addr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  fmap_ram #(
    .DEPTH     (DEPTH),
    .DATA_BITS (DATA_BITS),
    .CHANNELS  (CHANNELS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_c),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (re_c),
    .rd_addr (rd_addr),
    .rd_ch   (rd_ch),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Scoreboard bench for fmap_stream_tx: each frame's expected 432-word stream
// is queued when its writes are driven and compared as words emerge.
module tb_fmap_stream_tx;

  localparam int DB  = 14;
  localparam int NPX = 144;
  localparam int NCH = 3;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DB-1:0] d;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] data_in_0, data_in_1, data_in_2;
  logic          ready_in, valid_out, frame_done, overflow;
  logic [DB-1:0] data_out;
  logic [1:0]    ch_idx;

  exp_t          sb[$];
  logic [DB-1:0] fr [NCH][NPX];
  int            vec = 0;
  int            errs = 0;
  int            words = 0;
  int            cyc = 0;
  int            last_wr_cyc = 0;
  bit            first_pending = 1'b0;
  bit            chk_ready_next = 1'b0;

  fmap_stream_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .ch_idx     (ch_idx),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: compare every emitted word against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (chk_ready_next) begin
        chk_ready_next = 1'b0;
        check("ready_after_done", 32'(ready_in), 32'd1);
        check("idle_after_done", 32'(valid_out), 32'd0);
      end
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(valid_out), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", 32'(data_out), 32'(e.d));
          check("ch_idx", 32'(ch_idx), 32'(e.ch));
          check("frame_done", 32'(frame_done), 32'(e.last));
          words++;
          if (first_pending) begin
            first_pending = 1'b0;
            check("first_latency", 32'(cyc - last_wr_cyc), 32'd1);
          end
          if (frame_done) begin
            check("ready_at_done", 32'(ready_in), 32'd0);
            chk_ready_next = 1'b1;
          end
        end
      end else if (frame_done) begin
        check("done_without_valid", 32'(frame_done), 32'd0);
      end
    end
  end

  // Fill the frame image: 0 = c*1000+p, 1 = random with negative corners, 2 = offset data.
  task automatic build_frame(input int mode);
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < NPX; p++) begin
        case (mode)
          0:       fr[c][p] = DB'(c * 1000 + p);
          1:       fr[c][p] = DB'($urandom);
          default: fr[c][p] = DB'(c * 1000 + p + 5000);
        endcase
      end
    end
    if (mode == 1) begin
      fr[0][0]   = 14'h2000;
      fr[0][143] = 14'h3FFF;
      fr[1][0]   = 14'h3FFF;
      fr[2][77]  = 14'h2000;
      fr[2][143] = 14'h2001;
    end
  endtask

  // Queue the expected stream, then drive the 144 writes.
  task automatic send_frame(input int mode, input bit gap, input bit hold);
    exp_t e;
    build_frame(mode);
    for (int c = 0; c < NCH; c++) begin
      for (int p = 0; p < NPX; p++) begin
        e.ch   = 2'(c);
        e.d    = fr[c][p];
        e.last = (c == NCH - 1) && (p == NPX - 1);
        sb.push_back(e);
      end
    end
    for (int p = 0; p < NPX; p++) begin
      @(negedge clk);
      valid_in  = 1'b1;
      data_in_0 = fr[0][p];
      data_in_1 = fr[1][p];
      data_in_2 = fr[2][p];
      if (gap && p < NPX - 1) begin
        @(negedge clk);
        valid_in  = 1'b0;
        data_in_0 = 14'h1555;
        data_in_1 = 14'h1555;
        data_in_2 = 14'h1555;
      end
    end
    @(posedge clk);
    #1;
    last_wr_cyc   = cyc;
    first_pending = 1'b1;
    @(negedge clk);
    if (hold) begin
      data_in_0 = 14'h3FFF;
      data_in_1 = 14'h3FFF;
      data_in_2 = 14'h3FFF;
    end else begin
      valid_in = 1'b0;
    end
  endtask

  // Wait for the scoreboard to drain, bounded; then release valid_in.
  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int target;
    int t;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in_0 = '0;
    data_in_1 = '0;
    data_in_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_in), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ch", 32'(ch_idx), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contiguous frame.
    send_frame(0, 1'b0, 1'b0);
    wait_drain();
    check("ovf_clean_a", 32'(overflow), 32'd0);

    // Same frame with valid_in toggling.
    send_frame(0, 1'b1, 1'b0);
    wait_drain();
    check("ovf_clean_b", 32'(overflow), 32'd0);

    // Negative samples, valid_in held high through DRAIN.
    send_frame(1, 1'b0, 1'b1);
    wait_drain();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ready_idle", 32'(ready_in), 32'd1);

    // Following frame must carry none of the dropped data.
    send_frame(0, 1'b0, 1'b0);
    wait_drain();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of DRAIN at word 200.
    send_frame(0, 1'b0, 1'b0);
    target = words + 199;
    t = 0;
    while (words < target && t < 1000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("mid_drain_reach", 32'(words >= target), 32'd1);
    check("mid_drain_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_data", 32'(data_out), 32'd0);
    check("async_ready", 32'(ready_in), 32'd1);
    check("async_ovf", 32'(overflow), 32'd0);
    sb.delete();
    first_pending  = 1'b0;
    chk_ready_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(valid_out), 32'd0);

    // Fresh frame after reset with new data only.
    send_frame(2, 1'b0, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
